// File: rtl/jt51_opsched.sv
// Operator scheduler for the 32-slot, 4-op FM pipeline: slot counter, CON/FB tables, stage-I control.
// Optional JT51_OPSCHED_HOLD_EN adds hold/step inputs to freeze or single-step the slot counter.
module jt51_opsched #(
  parameter int SLOTS    = 32,
  parameter int CHANNELS = SLOTS/4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       cfg_wr,
  input  logic [2:0] cfg_ch,
  input  logic [2:0] cfg_con,
  input  logic [2:0] cfg_fb,
`ifdef JT51_OPSCHED_HOLD_EN
  input  logic       hold,
  input  logic       step,
`endif
  output logic [4:0] slot,
  output logic       zero,
  output logic       m1_enters,
  output logic       m2_enters,
  output logic       c1_enters,
  output logic       c2_enters,
  output logic [2:0] con_I,
  output logic [2:0] fb_II,
  output logic       use_prevprev1,
  output logic       use_prev1,
  output logic       use_prev2,
  output logic       use_internal_x,
  output logic       use_internal_y
);

  generate
    if (SLOTS != 32 || CHANNELS * 4 != SLOTS) begin : g_bad_cfg
      $error("jt51_opsched supports only SLOTS=32, CHANNELS=8");
    end
  endgenerate

  logic [2:0] con_table [CHANNELS];
  logic [2:0] fb_table  [CHANNELS];

  logic       advance;
  logic [4:0] slot_next;
  logic [2:0] con_next;
  logic [7:0] a;
  logic       m1_n, m2_n, c1_n, c2_n;

`ifdef JT51_OPSCHED_HOLD_EN
  assign advance = cen & (~hold | step);
`else
  assign advance = cen;
`endif

  // Everything registered on an advance is decoded from the slot being entered.
  always_comb begin
    slot_next = slot + 5'd1;
    con_next  = con_table[slot_next[2:0]];
    a         = 8'd1 << con_next;
    m1_n      = (slot_next[4:3] == 2'd0);
    m2_n      = (slot_next[4:3] == 2'd1);
    c1_n      = (slot_next[4:3] == 2'd2);
    c2_n      = (slot_next[4:3] == 2'd3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        con_table[i] <= '0;
        fb_table[i]  <= '0;
      end
      slot           <= '0;
      zero           <= 1'b1;
      m1_enters      <= 1'b1;
      m2_enters      <= 1'b0;
      c1_enters      <= 1'b0;
      c2_enters      <= 1'b0;
      con_I          <= '0;
      fb_II          <= '0;
      use_prevprev1  <= 1'b1;
      use_prev1      <= 1'b1;
      use_prev2      <= 1'b0;
      use_internal_x <= 1'b0;
      use_internal_y <= 1'b0;
    end else begin
      // Table writes land at the edge; a same-edge output load still sees the old entry.
      if (cfg_wr) begin
        con_table[cfg_ch] <= cfg_con;
        fb_table[cfg_ch]  <= cfg_fb;
      end
      if (advance) begin
        slot           <= slot_next;
        zero           <= (slot_next == 5'd0);
        m1_enters      <= m1_n;
        m2_enters      <= m2_n;
        c1_enters      <= c1_n;
        c2_enters      <= c2_n;
        con_I          <= con_next;
        fb_II          <= fb_table[slot[2:0]];
        use_prevprev1  <= m1_n | (m2_n & a[5]);
        use_prev2      <= (m2_n & (a[0] | a[1] | a[2])) | (c2_n & a[3]);
        use_internal_x <= c2_n & a[2];
        use_internal_y <= c2_n & (a[0] | a[1] | a[3] | a[4]);
        use_prev1      <= m1_n | (m2_n & a[1]) | (c1_n & (a[0] | a[3] | a[4] | a[6]))
                          | (c2_n & (a[2] | a[5]));
      end
    end
  end

endmodule

// File: tb/tb_jt51_opsched.sv
// Self-checking bench for jt51_opsched: scoreboard against a slot/table model plus table-driven slot vectors.
module tb_jt51_opsched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [2:0] cfg_ch = '0, cfg_con = '0, cfg_fb = '0;
  logic       hold = 1'b0, step = 1'b0;
  logic [4:0] slot;
  logic       zero, m1_enters, m2_enters, c1_enters, c2_enters;
  logic [2:0] con_I, fb_II;
  logic       use_prevprev1, use_prev1, use_prev2, use_internal_x, use_internal_y;

  always #5 clk = ~clk;

  jt51_opsched dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch), .cfg_con(cfg_con), .cfg_fb(cfg_fb),
`ifdef JT51_OPSCHED_HOLD_EN
    .hold(hold), .step(step),
`endif
    .slot(slot), .zero(zero),
    .m1_enters(m1_enters), .m2_enters(m2_enters), .c1_enters(c1_enters), .c2_enters(c2_enters),
    .con_I(con_I), .fb_II(fb_II),
    .use_prevprev1(use_prevprev1), .use_prev1(use_prev1), .use_prev2(use_prev2),
    .use_internal_x(use_internal_x), .use_internal_y(use_internal_y)
  );

  typedef struct {
    logic [4:0] slot;
    logic       zero;
    logic [3:0] ent;   // {m1,m2,c1,c2}
    logic [2:0] con;
    logic [2:0] fb;
    logic [4:0] sel;   // {prevprev1,prev1,prev2,internal_x,internal_y}
  } exp_t;

  typedef struct {
    logic [4:0] slot;
    logic [2:0] con;
    logic [4:0] sel;
    logic       chk_fb;
    logic [2:0] fb;
  } vec_t;

  int n_checks = 0;
  int n_fails  = 0;

  logic [4:0] m_slot = '0;
  logic [2:0] m_con [8];
  logic [2:0] m_fb  [8];
  logic [2:0] m_fbii = '0;
  exp_t       sb [$];

  function automatic exp_t model_out(input logic [4:0] s, input logic [2:0] c, input logic [2:0] f);
    exp_t e;
    logic [7:0] a;
    logic m1, m2, c1, c2;
    a  = 8'd1 << c;
    m1 = (s[4:3] == 2'd0); m2 = (s[4:3] == 2'd1);
    c1 = (s[4:3] == 2'd2); c2 = (s[4:3] == 2'd3);
    e.slot = s;
    e.zero = (s == 5'd0);
    e.ent  = {m1, m2, c1, c2};
    e.con  = c;
    e.fb   = f;
    e.sel  = {m1 | (m2 & a[5]),
              m1 | (m2 & a[1]) | (c1 & (a[0] | a[3] | a[4] | a[6])) | (c2 & (a[2] | a[5])),
              (m2 & (a[0] | a[1] | a[2])) | (c2 & a[3]),
              c2 & a[2],
              c2 & (a[0] | a[1] | a[3] | a[4])};
    return e;
  endfunction

  function automatic logic [4:0] dut_sel();
    return {use_prevprev1, use_prev1, use_prev2, use_internal_x, use_internal_y};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s slot=%0d actual=%0h required=%0h", name, slot, act, req);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".slot"}, {3'b0, slot}, {3'b0, e.slot});
    chk({tag, ".zero"}, {7'b0, zero}, {7'b0, e.zero});
    chk({tag, ".enters"}, {4'b0, m1_enters, m2_enters, c1_enters, c2_enters}, {4'b0, e.ent});
    chk({tag, ".con_I"}, {5'b0, con_I}, {5'b0, e.con});
    chk({tag, ".fb_II"}, {5'b0, fb_II}, {5'b0, e.fb});
    chk({tag, ".sel"}, {3'b0, dut_sel()}, {3'b0, e.sel});
  endtask

  task automatic model_reset();
    m_slot = '0; m_fbii = '0;
    for (int i = 0; i < 8; i++) begin m_con[i] = '0; m_fb[i] = '0; end
  endtask

  // One clock: drive on negedge, update model at posedge, compare #1 later.
  task automatic tick(input logic c, input logic wr = 1'b0, input logic [2:0] ch = 3'd0,
                      input logic [2:0] cn = 3'd0, input logic [2:0] fb = 3'd0);
    exp_t e;
    @(negedge clk);
    cen = c; cfg_wr = wr; cfg_ch = ch; cfg_con = cn; cfg_fb = fb;
    @(posedge clk);
    if (c && (!hold || step)) begin
      m_fbii = m_fb[m_slot[2:0]];
      m_slot = m_slot + 5'd1;
    end
    sb.push_back(model_out(m_slot, m_con[m_slot[2:0]], m_fbii));
    if (wr) begin m_con[ch] = cn; m_fb[ch] = fb; end
    #1;
    cen = 1'b0; cfg_wr = 1'b0;
    e = sb.pop_front();
    chk_all("tick", e);
    $display("tick cen=%0b wr=%0b slot=%0d con_I=%0d fb_II=%0d sel=%b", c, wr, slot, con_I, fb_II, dut_sel());
  endtask

  task automatic run_to(input logic [4:0] target);
    int n;
    n = 0;
    while (m_slot != target && n < 64) begin tick(1'b1); n++; end
    n_checks++;
    if (m_slot != target) begin
      n_fails++;
      $display("FAIL run_to timeout actual=%0d required=%0d", m_slot, target);
    end
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{slot: 5'd3,  con: 3'd7, sel: 5'b11000, chk_fb: 1'b0, fb: 3'd0};
    vecs[1] = '{slot: 5'd4,  con: 3'd0, sel: 5'b11000, chk_fb: 1'b1, fb: 3'd5};
    vecs[2] = '{slot: 5'd10, con: 3'd0, sel: 5'b00100, chk_fb: 1'b0, fb: 3'd0};
    vecs[3] = '{slot: 5'd11, con: 3'd7, sel: 5'b00000, chk_fb: 1'b1, fb: 3'd1};
    vecs[4] = '{slot: 5'd18, con: 3'd0, sel: 5'b01000, chk_fb: 1'b0, fb: 3'd0};
    vecs[5] = '{slot: 5'd26, con: 3'd0, sel: 5'b00001, chk_fb: 1'b0, fb: 3'd0};
    vecs[6] = '{slot: 5'd29, con: 3'd2, sel: 5'b01010, chk_fb: 1'b0, fb: 3'd0};

    model_reset();
    #23;
    chk_all("reset", model_out(5'd0, 3'd0, 3'd0));
    chk("reset.sel_const", {3'b0, dut_sel()}, 8'h18);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 3; i++) tick(1'b0);
    for (int i = 0; i < 32; i++) tick(1'b1);

    tick(1'b0, 1'b1, 3'd3, 3'd7, 3'd5);
    tick(1'b0, 1'b1, 3'd2, 3'd0, 3'd1);
    tick(1'b0, 1'b1, 3'd5, 3'd2, 3'd3);
    foreach (vecs[i]) begin
      run_to(vecs[i].slot);
      chk($sformatf("vec%0d.con_I", i), {5'b0, con_I}, {5'b0, vecs[i].con});
      chk($sformatf("vec%0d.sel", i), {3'b0, dut_sel()}, {3'b0, vecs[i].sel});
      if (vecs[i].chk_fb) chk($sformatf("vec%0d.fb_II", i), {5'b0, fb_II}, {5'b0, vecs[i].fb});
    end

    // Write landing on the same edge that loads ch4 keeps the old CON.
    run_to(5'd3);
    tick(1'b1, 1'b1, 3'd4, 3'd5, 3'd2);
    chk("same_edge.con_I", {5'b0, con_I}, 8'd0);
    run_to(5'd12);
    chk("ch4_next.con_I", {5'b0, con_I}, 8'd5);
    chk("ch4_next.prevprev1", {7'b0, use_prevprev1}, 8'd1);

    tick(1'b0, 1'b1, 3'd6, 3'd1, 3'd0);
    tick(1'b0, 1'b1, 3'd6, 3'd4, 3'd0);
    run_to(5'd14);
    chk("last_wins.con_I", {5'b0, con_I}, 8'd4);
    chk("last_wins.sel", {3'b0, dut_sel()}, 8'h00);

    // Asynchronous reset mid-frame.
    run_to(5'd20);
    @(negedge clk); #2; rst_n = 1'b0; #1;
    model_reset();
    chk_all("midreset", model_out(5'd0, 3'd0, 3'd0));
    @(negedge clk); rst_n = 1'b1;
    tick(1'b1);
    chk("after_reset.slot", {3'b0, slot}, 8'd1);

`ifdef JT51_OPSCHED_HOLD_EN
    hold = 1'b1;
    tick(1'b1);
    tick(1'b1);
    chk("hold.slot", {3'b0, slot}, 8'd1);
    step = 1'b1;
    tick(1'b1);
    step = 1'b0;
    chk("step.slot", {3'b0, slot}, 8'd2);
    hold = 1'b0;
    tick(1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jt51_opsched.md
Name: jt51_opsched

Overview:
- 32-slot operator scheduler for the 4-op FM pipeline.
- Owns the slot counter, channel algorithm (CON) and feedback (FB) tables.
- Drives the pipeline's stage-I control: operator-group enter flags, CON, modulation-source selects, plus FB one stage later.
- Time order: M1 ch0-7, M2 ch0-7, C1 ch0-7, C2 ch0-7; one slot per cen.

Parameters:
- SLOTS, 32, slots per sample frame; only 32 is supported, other values are an elaboration error.
- CHANNELS, 8, channels per operator group; SLOTS/4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  clock enable; one slot advance per cen-qualified edge
- cfg_wr  in  1  write strobe for channel config; acts on any posedge, independent of cen
- cfg_ch  in  3  channel to write
- cfg_con  in  3  algorithm 0-7
- cfg_fb  in  3  feedback level 0-7
- slot  out  5  current stage-I slot index
- zero  out  1  high while slot==0
- m1_enters, m2_enters, c1_enters, c2_enters  out  1 each  group decode of slot[4:3] (00/01/10/11)
- con_I  out  3  CON of the current slot's channel
- fb_II  out  3  FB of the previous slot's channel (one cen later than con_I)
- use_prevprev1, use_prev1, use_prev2, use_internal_x, use_internal_y  out  1 each  modulation selects

Behaviour:
- Reset (rst_n low, async): slot=0, con/fb tables=0, fb_II=0.
- Outputs during reset reflect the slot-0/con-0 state:
  - zero=1, m1_enters=1, other enters=0, con_I=0.
  - use_prevprev1=1, use_prev1=1, other use_* =0.
- All outputs are registered. On each cen edge, slot advances mod 32 (31->0 wraps, zero rises).
- All other outputs update on the same edge and are decoded from the new slot value.
- No change without cen.
- Channel index is slot[2:0]. con_I = con_table[slot[2:0]].
- fb_II <= fb_table[slot[2:0]] sampled on cen, so it is the FB of the slot now in stage II.
- Let a[7:0] = one-hot of con_I. Selects:
  - use_prevprev1 = m1 | (m2 & a5)
  - use_prev2 = (m2 & (a0|a1|a2)) | (c2 & a3)
  - use_internal_x = c2 & a2
  - use_internal_y = c2 & (a0|a1|a3|a4)
  - use_prev1 = m1 | (m2 & a1) | (c1 & (a0|a3|a4|a6)) | (c2 & (a2|a5))
- Config writes:
  - cfg_wr writes both tables for cfg_ch at the edge.
  - If the same edge also loads outputs for that channel, outputs use the old value; the new value appears from the next slot of that channel.
  - Back-to-back writes to one channel: last write wins.
- rst_n asserted mid-frame aborts the frame immediately. Release restarts at slot 0 on the first cen.

Optional Feature:
- JT51_OPSCHED_HOLD_EN adds input hold (1 bit) and input step (1 bit).
- While hold=1:
  - slot and all outputs freeze even with cen.
  - A cen edge with step=1 advances exactly one slot.
  - cfg writes still apply.
- Without the macro, the ports do not exist and the counter free-runs on cen.

Test Plan:
- Reset then 32 cen pulses -> slot 0..31 then 0; zero high only at slot 0; m1 slots 0-7, m2 8-15, c1 16-23, c2 24-31; no advance with cen low.
- Write ch3 con=7, fb=5; run to slot 3 -> con_I=7, use_prevprev1=1, use_prev1=1; next cen fb_II=5.
- con=0 on ch2 -> slot10: use_prevprev1=0, use_prev2=1, use_prev1=0; slot18: use_prev1=1; slot26: use_internal_y=1, others 0.
- con=2 on ch5 -> slot29: use_internal_x=1, use_prev1=1, use_internal_y=0.
- cfg_wr ch4 con=5 on the same edge slot becomes 4 -> con_I holds old value 0; slot 12 shows con_I=5 and use_prevprev1=1.
- Assert rst_n low at slot 20 between edges -> outputs return to reset values immediately; after release, first cen gives slot=1.
